nacc_engine: RTL and testbench

//  Multi-cycle neuron engine driven by the NSR control group decoded in ID (NSRwrite, SorNACC, NACC_VL, VL).
//  Two operations, both ending in a neuron-state write-back:
//   - NACC: accumulates WVR weights gated by SVR spike bits into the neuron potential.
//   - FIRE: applies leak and a threshold test to the potential.

---
 rtl/nacc_pkg.sv | 20 ++
 rtl/nacc_engine_sat_add.sv | 23 ++
 rtl/nacc_engine.sv | 164 ++++++++++++++++
 tb/tb_nacc_engine.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/nacc_pkg.sv
// Shared types and default widths for the neuron accumulate/fire engine.
// The register files use the same widths, so both sides import them from here.
package nacc_pkg;

    localparam int DEF_LANES      = 4;
    localparam int DEF_WEIGHT_W   = 8;
    localparam int DEF_POT_W      = 16;
    localparam int DEF_LEAK_SHIFT = 3;

    localparam logic OP_NACC = 1'b1;
    localparam logic OP_FIRE = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2,
        WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/nacc_engine_sat_add.sv
// Signed saturating adder: the sum clamps to the most positive or most
// negative W-bit value instead of wrapping.
module sat_add #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

    logic signed [W:0] full;

    // Overflow shows up as a mismatch between the extra sign bit and the top result bit.
    always_comb begin
        full = {a[W-1], a} + {b[W-1], b};
        if (full[W] != full[W-1]) begin
            y = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            y = full[W-1:0];
        end
    end

endmodule

// File: rtl/nacc_engine.sv
// Multi-cycle neuron engine in EX: NACC adds spike-gated weights into the
// potential one lane per cycle, FIRE applies leak and threshold; both write back to NSR.
module nacc_engine
    import nacc_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int WEIGHT_W   = DEF_WEIGHT_W,
    parameter int POT_W      = DEF_POT_W,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      sor_nacc,
    input  logic                      nacc_vl,
    input  logic [1:0]                vl,
    input  logic [LANES*WEIGHT_W-1:0] wvr_data,
    input  logic [LANES-1:0]          svr_data,
    input  logic signed [POT_W-1:0]   nsr_in,
    input  logic signed [POT_W-1:0]   threshold,
    output logic                      busy,
    output logic                      nsr_we,
    output logic signed [POT_W-1:0]   nsr_out,
    output logic                      spike_out,
    output logic                      done
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t state, state_next;

    logic                      op_q;
    logic [LANE_W-1:0]         lane_cnt;
    logic [LANE_W-1:0]         last_lane_q;
    logic [LANE_W-1:0]         last_lane_d;
    logic [LANES*WEIGHT_W-1:0] wvr_q;
    logic [LANES-1:0]          svr_q;
    logic signed [POT_W-1:0]   thr_q;
    logic signed [POT_W-1:0]   acc;
    logic                      spike_q;
    logic                      accept;

    logic [WEIGHT_W-1:0]       lane_weight;
    logic signed [POT_W-1:0]   lane_ext;
    logic signed [POT_W-1:0]   sum;
    logic signed [POT_W-1:0]   leak;
    logic signed [POT_W-1:0]   leaked;
    logic                      fire_hit;

    // Requested lane count vl+1 never exceeds the physical lane count.
    always_comb begin
        last_lane_d = LANE_W'(LANES - 1);
        if (nacc_vl && (int'(vl) < LANES)) begin
            last_lane_d = LANE_W'(vl);
        end
    end

    always_comb begin
        lane_weight = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_cnt == LANE_W'(i)) begin
                lane_weight = wvr_q[i*WEIGHT_W +: WEIGHT_W];
            end
        end
        lane_ext = {{(POT_W-WEIGHT_W){lane_weight[WEIGHT_W-1]}}, lane_weight};
        leak     = acc >>> LEAK_SHIFT;
        leaked   = acc - leak;
        fire_hit = (leaked >= thr_q);
    end

    sat_add #(
        .W (POT_W)
    ) u_sat_add (
        .a (acc),
        .b (lane_ext),
        .y (sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Starts are honoured only from IDLE, so re-pulses mid-op or in WRITE are dropped.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        nsr_we     = 1'b0;
        done       = 1'b0;
        nsr_out    = '0;
        spike_out  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (sor_nacc == OP_NACC) ? ACCUM : FIRE;
                end
            end
            ACCUM: begin
                if (lane_cnt == last_lane_q) begin
                    state_next = WRITE;
                end
            end
            FIRE: begin
                state_next = WRITE;
            end
            WRITE: begin
                nsr_we     = 1'b1;
                done       = 1'b1;
                nsr_out    = acc;
                spike_out  = spike_q && (op_q == OP_FIRE);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= 1'b0;
            lane_cnt    <= '0;
            last_lane_q <= '0;
            wvr_q       <= '0;
            svr_q       <= '0;
            thr_q       <= '0;
            acc         <= '0;
            spike_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q        <= sor_nacc;
                        last_lane_q <= last_lane_d;
                        wvr_q       <= wvr_data;
                        svr_q       <= svr_data;
                        thr_q       <= threshold;
                        acc         <= nsr_in;
                        lane_cnt    <= '0;
                        spike_q     <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (svr_q[lane_cnt]) begin
                        acc <= sum;
                    end
                    lane_cnt <= lane_cnt + 1'b1;
                end
                FIRE: begin
                    spike_q <= fire_hit;
                    acc     <= fire_hit ? '0 : leaked;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nacc_engine.sv
// Self-checking bench for nacc_engine: directed cases plus random ops compared
// against an integer reference model of the accumulate/fire rules.
module tb_nacc_engine;
    import nacc_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               sor_nacc = 1'b0;
    logic               nacc_vl = 1'b0;
    logic [1:0]         vl = '0;
    logic [31:0]        wvr_data = '0;
    logic [3:0]         svr_data = '0;
    logic signed [15:0] nsr_in = '0;
    logic signed [15:0] threshold = '0;
    logic               busy;
    logic               nsr_we;
    logic signed [15:0] nsr_out;
    logic               spike_out;
    logic               done;

    int checks = 0;
    int errors = 0;

    nacc_engine dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sor_nacc  (sor_nacc),
        .nacc_vl   (nacc_vl),
        .vl        (vl),
        .wvr_data  (wvr_data),
        .svr_data  (svr_data),
        .nsr_in    (nsr_in),
        .threshold (threshold),
        .busy      (busy),
        .nsr_we    (nsr_we),
        .nsr_out   (nsr_out),
        .spike_out (spike_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: integer sums clamped after every add; leak as floor(pot/2^3).
    function automatic void model(input bit op, input bit nvl, input logic [1:0] v,
                                  input logic [31:0] w, input logic [3:0] s,
                                  input int nsr, input int thr,
                                  output int n, output int res, output bit spk);
        int acc;
        int p;
        acc = nsr;
        spk = 1'b0;
        n   = 0;
        if (op) begin
            n = nvl ? ((int'(v) + 1 > 4) ? 4 : int'(v) + 1) : 4;
            for (int i = 0; i < n; i++) begin
                if (s[i]) begin
                    acc = acc + int'($signed(w[i*8 +: 8]));
                    if (acc > 32767)  acc = 32767;
                    if (acc < -32768) acc = -32768;
                end
            end
            res = acc;
        end else begin
            p = acc - (acc >>> 3);
            if (p >= thr) begin
                spk = 1'b1;
                res = 0;
            end else begin
                res = p;
            end
        end
    endfunction

    task automatic scrambleOperands();
        sor_nacc  = 1'($urandom());
        nacc_vl   = 1'($urandom());
        vl        = 2'($urandom());
        wvr_data  = $urandom();
        svr_data  = 4'($urandom());
        nsr_in    = 16'($urandom());
        threshold = 16'($urandom());
    endtask

    task automatic applyStimulus(input string tag, input bit op, input bit nvl,
                                 input logic [1:0] v, input logic [31:0] w,
                                 input logic [3:0] s, input logic signed [15:0] nsr,
                                 input logic signed [15:0] thr, input bit repulse);
        int n;
        int exp_res;
        int exp_wr;
        bit exp_spk;
        model(op, nvl, v, w, s, int'(nsr), int'(thr), n, exp_res, exp_spk);
        exp_wr = op ? n + 1 : 2;
        @(negedge clk);
        sor_nacc  = op;
        nacc_vl   = nvl;
        vl        = v;
        wvr_data  = w;
        svr_data  = s;
        nsr_in    = nsr;
        threshold = thr;
        start     = 1'b1;
        for (int k = 1; k <= exp_wr + 2; k++) begin
            @(negedge clk);
            checkOutput($sformatf("%s.busy@%0d", tag, k), busy, (k <= exp_wr) ? 1 : 0);
            checkOutput($sformatf("%s.nsr_we@%0d", tag, k), nsr_we, (k == exp_wr) ? 1 : 0);
            checkOutput($sformatf("%s.done@%0d", tag, k), done, (k == exp_wr) ? 1 : 0);
            if (k == exp_wr) begin
                checkOutput({tag, ".nsr_out"}, nsr_out, exp_res);
                checkOutput({tag, ".spike_out"}, spike_out, exp_spk ? 1 : 0);
            end
            scrambleOperands();
            start = repulse && (k == 2 || k == exp_wr);
        end
        start = 1'b0;
    endtask

    initial begin
        int we_seen;
        bit op;
        $display("[TB] starting nacc_engine bench");

        #2;
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.nsr_we", nsr_we, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.spike_out", spike_out, 0);
        checkOutput("reset.nsr_out", nsr_out, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("t1_nacc4", 1'b1, 1'b0, 2'd0, 32'h04FD0705, 4'b1011, 16'sd10, 16'sd0, 1'b0);
        applyStimulus("t2_vl1", 1'b1, 1'b1, 2'd1, 32'h02020202, 4'b1111, 16'sd0, 16'sd0, 1'b0);
        applyStimulus("t3_satpos", 1'b1, 1'b0, 2'd0, 32'h00006464, 4'b0011, 16'sd32760, 16'sd0, 1'b0);
        applyStimulus("t3_satneg", 1'b1, 1'b0, 2'd0, 32'h00329C9C, 4'b0111, -16'sd32760, 16'sd0, 1'b0);
        applyStimulus("t3_nospk", 1'b1, 1'b0, 2'd0, 32'h7F7F7F7F, 4'b0000, -16'sd1234, 16'sd0, 1'b0);
        applyStimulus("t4_fire", 1'b0, 1'b0, 2'd0, 32'h0, 4'b0, 16'sd80, 16'sd60, 1'b0);
        applyStimulus("t4_leak", 1'b0, 1'b0, 2'd0, 32'h0, 4'b0, 16'sd40, 16'sd60, 1'b0);
        applyStimulus("t4_negleak", 1'b0, 1'b0, 2'd0, 32'h0, 4'b0, -16'sd81, -16'sd100, 1'b0);
        applyStimulus("t5_repulse", 1'b1, 1'b0, 2'd0, 32'h01020304, 4'b1111, 16'sd5, 16'sd0, 1'b1);
        applyStimulus("t5_firerep", 1'b0, 1'b0, 2'd0, 32'h0, 4'b0, 16'sd200, 16'sd500, 1'b1);

        @(negedge clk);
        sor_nacc = 1'b1;
        nacc_vl  = 1'b0;
        wvr_data = 32'h01010101;
        svr_data = 4'b1111;
        nsr_in   = 16'sd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst.busy", busy, 0);
        checkOutput("t6_rst.nsr_we", nsr_we, 0);
        checkOutput("t6_rst.done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        we_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (nsr_we || done || busy) we_seen++;
        end
        checkOutput("t6_rst.no_writeback", we_seen, 0);
        applyStimulus("t6_clean", 1'b1, 1'b0, 2'd0, 32'hFF030201, 4'b1101, 16'sd100, 16'sd0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            op = 1'($urandom());
            applyStimulus($sformatf("rnd%0d", r), op, 1'($urandom()), 2'($urandom()),
                          $urandom(), 4'($urandom()), 16'($urandom()),
                          op ? 16'sd0 : 16'($urandom()), 1'($urandom()));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
